pipe_stage_reg: RTL and testbench

//  Generic parametrised pipeline-stage register; replaces fixed per-stage regs (IF/ID, ID/EX, ...).

---
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid pipeline stage register; optional perf counters via PIPE_STAGE_PERF_EN
module pipe_stage_reg #(
  parameter int         PAYLOAD_W    = 96,
  parameter logic [2:0] INVALID_TYPE = 3'd7
`ifdef PIPE_STAGE_PERF_EN
  , parameter int       CNT_W        = 16
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_type,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_type,
  output logic [PAYLOAD_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t               state;
  logic [2:0]           main_type;
  logic [PAYLOAD_W-1:0] main_data;
  logic [2:0]           skid_type;
  logic [PAYLOAD_W-1:0] skid_data;

  logic accept;
  logic deliver;

  // Handshake flags come straight from the state register so in_ready never depends on inputs.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_type  = out_valid ? main_type : INVALID_TYPE;
  assign out_data  = main_data;
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  // Occupancy FSM: main register feeds the output, skid catches the entry accepted during a stall.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      state     <= EMPTY;
      main_type <= INVALID_TYPE;
      main_data <= '0;
      skid_type <= INVALID_TYPE;
      skid_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            main_type <= in_type;
            main_data <= in_data;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_type <= in_type;
            main_data <= in_data;
          end else if (accept) begin
            state     <= TWO;
            skid_type <= in_type;
            skid_data <= in_data;
          end else if (deliver) begin
            state     <= EMPTY;
            main_type <= INVALID_TYPE;
            main_data <= '0;
          end
        end
        TWO: begin
          if (deliver) begin
            state     <= ONE;
            main_type <= skid_type;
            main_data <= skid_data;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Saturating stall/bubble counters; only reset clears them, flush leaves history intact.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

  localparam int PW = 96;
`ifdef PIPE_STAGE_PERF_EN
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_type;
  logic [PW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_type;
  logic [PW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  int               stall_m;
  int               bubble_m;
`endif

  int checks = 0;
  int errors = 0;

  // Model: FIFO of up to two {type, data} entries; head is what the stage presents.
  logic [PW+2:0] q[$];

  always #5 clock = ~clock;

  pipe_stage_reg #(
    .PAYLOAD_W(PW),
    .INVALID_TYPE(3'd7)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_type(in_type),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_type(out_type),
    .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  function automatic logic [PW+4:0] exp_vec();
    if (q.size() == 0) return {1'b1, 1'b0, 3'd7, {PW{1'b0}}};
    return {(q.size() < 2), 1'b1, q[0]};
  endfunction

  function automatic logic [PW+4:0] obs_vec();
    return {in_ready, out_valid, out_type, (out_valid ? out_data : {PW{1'b0}})};
  endfunction

  function automatic logic [PW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Advance one clock, apply the handshake rules to the model, then settle past the edge.
  task automatic tick();
    bit acc, del;
    @(posedge clock);
`ifdef PIPE_STAGE_PERF_EN
    if (!reset) begin
      stall_m  = 0;
      bubble_m = 0;
    end else begin
      if (q.size() > 0 && !out_ready && stall_m < CNT_MAX) stall_m++;
      if (q.size() == 0 && bubble_m < CNT_MAX) bubble_m++;
    end
`endif
    if (!reset || flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      del = (q.size() > 0) && out_ready;
      if (del) void'(q.pop_front());
      if (acc) q.push_back({in_type, in_data});
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_type = 3'd2; in_data = rand_data(); out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({out_valid, out_type, out_data} !== {1'b0, 3'd7, {PW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b t=%0d d=%h expected v=0 t=7 d=0", out_valid, out_type, out_data);
    end
    reset = 1'b1; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] a [4];
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a[i] = rand_data();
      in_valid = 1'b1; in_type = 3'd1; in_data = a[i];
      tick();
      checks++;
      if ({in_ready, out_valid, out_type, out_data} !== {1'b1, 1'b1, 3'd1, a[i]}) begin
        errors++;
        $display("FAIL b2b_%0d: got r=%b v=%b t=%0d d=%h expected r=1 v=1 t=1 d=%h",
                 i, in_ready, out_valid, out_type, out_data, a[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL b2b_drain: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stall_skid();
    logic [PW-1:0] seen [3];
    out_ready = 1'b0; in_valid = 1'b1; in_type = 3'd3;
    in_data = PW'(32'h11);
    tick();
    in_data = PW'(32'h22);
    tick();
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, PW'(32'h11)}) begin
      errors++;
      $display("FAIL skid_full: got r=%b v=%b d=%h expected r=0 v=1 d=11", in_ready, out_valid, out_data);
    end
    in_data = PW'(32'h33);
    tick();
    checks++;
    if ({in_ready, out_data} !== {1'b0, PW'(32'h11)} || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL skid_hold: got r=%b d=%h expected r=0 d=11", in_ready, out_data);
    end
    seen[0] = out_data;
    out_ready = 1'b1;
    tick();
    seen[1] = out_data;
    tick();
    seen[2] = out_data;
    in_valid = 1'b0;
    checks++;
    if ({seen[0], seen[1], seen[2]} !== {PW'(32'h11), PW'(32'h22), PW'(32'h33)}) begin
      errors++;
      $display("FAIL skid_order: got %0h,%0h,%0h expected 11,22,33", seen[0], seen[1], seen[2]);
    end
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL skid_drain: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_flush();
    bit leaked = 0;
    out_ready = 1'b0; in_valid = 1'b1; in_type = 3'd4;
    in_data = rand_data(); tick();
    in_data = rand_data(); tick();
    flush = 1'b1; in_data = PW'(32'h44); out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, out_type, out_data, in_ready} !== {1'b0, 3'd7, {PW{1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL flush_state: got v=%b t=%0d d=%h r=%b expected v=0 t=7 d=0 r=1",
               out_valid, out_type, out_data, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid && out_data == PW'(32'h44)) leaked = 1;
    end
    checks++;
    if (leaked) begin
      errors++;
      $display("FAIL flush_drop: got 44 at output expected never");
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_type = 3'd5;
    in_data = rand_data(); tick();
    in_data = rand_data(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; in_valid = 1'b0;
    checks++;
    if ({out_valid, out_type, out_data, in_ready} !== {1'b0, 3'd7, {PW{1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid: got v=%b t=%0d d=%h r=%b expected v=0 t=7 d=0 r=1",
               out_valid, out_type, out_data, in_ready);
    end
    in_valid = 1'b1; in_type = 3'd6; in_data = PW'(32'h55); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_type, out_data} !== {1'b1, 3'd6, PW'(32'h55)}) begin
      errors++;
      $display("FAIL reset_mid_push: got v=%b t=%0d d=%h expected v=1 t=6 d=55", out_valid, out_type, out_data);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(1, 0) == 1;
      in_type   = 3'($urandom_range(7, 0));
      in_data   = rand_data();
      out_ready = $urandom_range(3, 0) != 0;
      flush     = $urandom_range(19, 0) == 0;
      reset     = $urandom_range(99, 0) != 0;
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
`ifdef PIPE_STAGE_PERF_EN
      checks++;
      if (stall_cnt !== CNT_W'(stall_m) || bubble_cnt !== CNT_W'(bubble_m)) begin
        errors++;
        $display("FAIL random_cnt_%0d: got s=%0d b=%0d expected s=%0d b=%0d", i, stall_cnt, bubble_cnt, stall_m, bubble_m);
      end
`endif
    end
    flush = 1'b0; reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({stall_cnt, bubble_cnt} !== {CNT_W'(0), CNT_W'(0)}) begin
      errors++;
      $display("FAIL perf_reset: got s=%0d b=%0d expected 0 0", stall_cnt, bubble_cnt);
    end
    in_valid = 1'b1; in_type = 3'd1; in_data = rand_data();
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (stall_cnt !== CNT_W'(5) || bubble_cnt !== CNT_W'(bubble_m)) begin
      errors++;
      $display("FAIL perf_stall5: got s=%0d b=%0d expected s=5 b=%0d", stall_cnt, bubble_cnt, bubble_m);
    end
    repeat (15) tick();
    checks++;
    if (stall_cnt !== CNT_W'(15)) begin
      errors++;
      $display("FAIL perf_saturate: got s=%0d expected 15", stall_cnt);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++;
    if (stall_cnt !== CNT_W'(15) || bubble_cnt !== CNT_W'(bubble_m)) begin
      errors++;
      $display("FAIL perf_flush: got s=%0d b=%0d expected s=15 b=%0d", stall_cnt, bubble_cnt, bubble_m);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({stall_cnt, bubble_cnt} !== {CNT_W'(0), CNT_W'(0)}) begin
      errors++;
      $display("FAIL perf_clear: got s=%0d b=%0d expected 0 0", stall_cnt, bubble_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_type = 3'd0; in_data = '0; out_ready = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    stall_m = 0; bubble_m = 0;
`endif
    #2;
    test_reset();
    test_back_to_back();
    test_stall_skid();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
